// File: rtl/key_lock_if.sv
// Key-event input and display/beep/lock outputs of the password lock.
interface key_lock_if;
  logic        key_flag;
  logic [3:0]  key_data;
  logic [23:0] show_data;
  logic [5:0]  blank_mask;
  logic        unlock;
  logic        beep_ok;
  logic        beep_err;
  logic        locked_out;

  modport master (
    output key_flag, key_data,
    input  show_data, blank_mask, unlock, beep_ok, beep_err, locked_out
  );

  modport slave (
    input  key_flag, key_data,
    output show_data, blank_mask, unlock, beep_ok, beep_err, locked_out
  );
endinterface

// File: rtl/key_lock_ctrl.sv
// Password lock controller: digit entry, compare, open window, failure
// display and lockout. Every output is a flop loaded from next-state values.
module key_lock_ctrl #(
  parameter logic [23:0] PASSWORD    = 24'h123456,
  parameter logic [30:0] OPEN_CYC    = 31'd250_000_000,
  parameter logic [30:0] FAIL_CYC    = 31'd50_000_000,
  parameter logic [30:0] IDLE_TO_CYC = 31'd500_000_000,
  parameter logic [30:0] LOCK_CYC    = 31'd1_500_000_000,
  parameter logic [2:0]  MAX_FAIL    = 3'd3
) (
  input  logic      sys_clk,
  input  logic      sys_rst_n,
  key_lock_if.slave kif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCKOUT
  } state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [2:0]  fail_cnt, fail_n;
  logic [30:0] timer, timer_n;
  logic [23:0] show_q, show_n;
  logic [5:0]  blank_q, blank_n;
  logic        unlock_q, ok_q, ok_n, err_q, err_n, lock_q;
  logic        clr, is_digit;

  assign is_digit = (kif.key_data <= 4'd9);

  // Next-state, counters and next output values.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fail_n  = fail_cnt;
    show_n  = show_q;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    clr     = 1'b0;
    case (state)
      S_IDLE: begin
        clr = 1'b1;
        if (kif.key_flag) begin
          if (is_digit) begin
            show_n  = {20'h0, kif.key_data};
            cnt_n   = 3'd1;
            ok_n    = 1'b1;
            state_n = S_ENTRY;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_ENTRY: begin
        if (kif.key_flag) begin
          // A key in the timeout cycle wins; the timer just restarts.
          if (timer == IDLE_TO_CYC - 31'd1) clr = 1'b1;
          if (is_digit) begin
            if (cnt < 3'd6) begin
              show_n = {show_q[19:0], kif.key_data};
              cnt_n  = cnt + 3'd1;
              ok_n   = 1'b1;
              clr    = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end else if (kif.key_data == 4'hA) begin
            show_n = {4'h0, show_q[23:4]};
            cnt_n  = cnt - 3'd1;
            ok_n   = 1'b1;
            clr    = 1'b1;
            if (cnt == 3'd1) state_n = S_IDLE;
          end else if (kif.key_data == 4'hB) begin
            ok_n    = 1'b1;
            state_n = S_IDLE;
          end else if (kif.key_data == 4'hF && cnt == 3'd6) begin
            state_n = S_CHECK;
          end else begin
            err_n = 1'b1;
          end
        end else if (timer == IDLE_TO_CYC - 31'd1) begin
          state_n = S_IDLE;
        end
      end
      S_CHECK: begin
        if (show_q == PASSWORD) begin
          fail_n  = 3'd0;
          state_n = S_OPEN;
        end else begin
          fail_n  = (fail_cnt == MAX_FAIL) ? fail_cnt : fail_cnt + 3'd1;
          err_n   = 1'b1;
          state_n = S_FAIL;
        end
      end
      S_OPEN: begin
        if (kif.key_flag) begin
          ok_n    = 1'b1;
          state_n = S_IDLE;
        end else if (timer == OPEN_CYC - 31'd1) begin
          state_n = S_IDLE;
        end
      end
      S_FAIL: begin
        if (timer == FAIL_CYC - 31'd1) begin
          if (fail_cnt == MAX_FAIL) begin
            err_n   = 1'b1;
            state_n = S_LOCKOUT;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_LOCKOUT: begin
        if (kif.key_flag) begin
          err_n = 1'b1;
          if (timer == LOCK_CYC - 31'd1) clr = 1'b1;
        end else if (timer == LOCK_CYC - 31'd1) begin
          fail_n  = 3'd0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (state_n != state) clr = 1'b1;
    timer_n = clr ? 31'd0 : timer + 31'd1;

    // Display content forced by the destination state.
    case (state_n)
      S_IDLE:              begin show_n = 24'h0; cnt_n = 3'd0; end
      S_OPEN:              show_n = 24'hAAAAAA;
      S_FAIL, S_LOCKOUT:   show_n = 24'hEEEEEE;
      default:             ;
    endcase

    case (state_n)
      S_IDLE:           blank_n = 6'h3F;
      S_ENTRY, S_CHECK: blank_n = 6'h3F << cnt_n;
      default:          blank_n = 6'h00;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      fail_cnt <= 3'd0;
      timer    <= 31'd0;
      show_q   <= 24'h0;
      blank_q  <= 6'h3F;
      unlock_q <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      fail_cnt <= fail_n;
      timer    <= timer_n;
      show_q   <= show_n;
      blank_q  <= blank_n;
      unlock_q <= (state_n == S_OPEN);
      ok_q     <= ok_n;
      err_q    <= err_n;
      lock_q   <= (state_n == S_LOCKOUT);
    end
  end

  assign kif.show_data  = show_q;
  assign kif.blank_mask = blank_q;
  assign kif.unlock     = unlock_q;
  assign kif.beep_ok    = ok_q;
  assign kif.beep_err   = err_q;
  assign kif.locked_out = lock_q;

endmodule

// File: doc/key_lock_ctrl.md
# key_lock_ctrl

Password-lock controller for the 4x4 keypad/display/beeper datapath. It consumes the one-cycle key event pulse and 4-bit key code produced downstream of the keyboard scanner and edge detector. It runs a digit-entry/compare/lockout state machine and drives the 6-digit display word, blank mask, beep request pulses and an unlock output. It sits between the key path and the seven-segment/beep drivers, replacing direct key-to-display wiring.

## Interface
- PASSWORD, 24'h123456, six hex digits; digit 5 = [23:20] is entered first.
- OPEN_CYC, 250_000_000, cycles `unlock` stays high (5 s @ 50 MHz).
- FAIL_CYC, 50_000_000, cycles the failure pattern is shown.
- IDLE_TO_CYC, 500_000_000, entry inactivity timeout.
- LOCK_CYC, 1_500_000_000, lockout duration.
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..7).
- All *_CYC values are ≥2 and <2^31.
- sys_clk  in  1  system clock; single clock domain.
- sys_rst_n  in  1  synchronous, active-low reset, sampled on rising sys_clk.
- key_flag  in  1  one-cycle key event pulse.
- key_data  in  4  key code, valid when key_flag=1.
- show_data  out  24  six hex digits to the display driver; digit 0 = [3:0].
- blank_mask  out  6  bit i=1 blanks digit i.
- unlock  out  1  lock-open level.
- beep_ok  out  1  one-cycle pulse, accepted key.
- beep_err  out  1  one-cycle pulse, rejected key / failure / lockout entry.
- locked_out  out  1  high during lockout.

## Operation
- Key classes: 0-9 = digit, A = backspace, B = clear, F = enter. C, D and E are rejected (beep_err).
- States: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT. A single 31-bit timer clears on every state change and on every accepted key.
- IDLE:
  - A digit loads into show_data[3:0], cnt=1, beep_ok, go to ENTRY.
  - A, B or F: beep_err, stay in IDLE.
- ENTRY:
  - Digit with cnt<6: show_data <= {show_data[19:0], key}, cnt+1, beep_ok.
  - Digit with cnt=6: beep_err, data unchanged.
  - A: shift right 4 bits, cnt-1, beep_ok; if cnt reaches 0, go to IDLE.
  - B: cnt=0, show_data=0, beep_ok, go to IDLE.
  - F with cnt=6: go to CHECK, no beep.
  - F with cnt<6: beep_err, stay in ENTRY.
  - Timer reaching IDLE_TO_CYC-1: clear, go to IDLE, fail count unchanged.
- CHECK (exactly 1 cycle):
  - show_data==PASSWORD: go to OPEN, fail_cnt=0.
  - Otherwise: fail_cnt+1, beep_err, go to FAIL.
- OPEN:
  - unlock=1, show_data=24'hAAAAAA.
  - Any key_flag relocks immediately (key consumed, beep_ok), go to IDLE.
  - Timer reaching OPEN_CYC-1 goes to IDLE.
- FAIL:
  - show_data=24'hEEEEEE; keys ignored, no beep.
  - After FAIL_CYC cycles: go to LOCKOUT if fail_cnt==MAX_FAIL (beep_err on entry), else go to IDLE.
- LOCKOUT:
  - locked_out=1, show_data=24'hEEEEEE.
  - Every key_flag gives beep_err, state unchanged.
  - After LOCK_CYC cycles: fail_cnt=0, go to IDLE.
- blank_mask:
  - IDLE: 6'h3F.
  - ENTRY: bit i = (i ≥ cnt).
  - CHECK: holds the ENTRY value.
  - OPEN/FAIL/LOCKOUT: 6'h00.
- Entering IDLE from any state sets show_data=0 and cnt=0.

## Timing
- Reset values: show_data=0, blank_mask=6'h3F, unlock=0, beep_ok=0, beep_err=0, locked_out=0; state IDLE, cnt=0, fail_cnt=0, timer=0.
- All outputs are registered. A key_flag sampled at edge N updates show_data, blank_mask and the beep pulse at edge N+1.
- Enter latency: F at edge N gives CHECK at N+1, and OPEN/unlock=1 (or FAIL plus beep_err) at N+2.
- beep_ok and beep_err never assert in the same cycle; each is exactly one cycle wide.
- A key_flag in the same cycle as timeout/expiry: the key is processed and the timer restarts. Exceptions: in FAIL the key is ignored; in OPEN the key relocks (same result as expiry).
- A back-to-back key_flag every cycle is legal; each one is processed.
- Reset asserted mid-operation (including in OPEN or LOCKOUT) forces all reset values at the next edge.
- fail_cnt saturates at MAX_FAIL.

## Test plan
- Reset, then keys 1,2,3,4,5,6,F → show_data steps 000001…123456; blank_mask 3E…00; unlock=1 two cycles after F; show AAAAAA; unlock=0 after OPEN_CYC=20 cycles; IDLE, blank 3F.
- Keys 1,2,3,4,5,7,F → beep_err at F+2, EEEEEE for FAIL_CYC, then IDLE; fail_cnt=1.
- Three wrong codes with MAX_FAIL=3 → LOCKOUT, locked_out=1; key 5 during lockout → beep_err only; after LOCK_CYC, IDLE and the correct code unlocks.
- Keys 1,2,A → show 000001, cnt=1; then B → show 0, IDLE. Seventh digit → beep_err; F after 5 digits → beep_err, stays in ENTRY.
- Key 3 then no activity, IDLE_TO_CYC=30 → IDLE at cycle 30, fail_cnt unchanged. Key 7 in OPEN → unlock=0 next cycle, beep_ok.
- sys_rst_n low for 1 cycle during OPEN → all outputs at reset values on the next edge.
